// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded MIPS register file.
package rf_pkg;

  localparam int          RF_DW      = 32;
  localparam int          RF_AW      = 5;
  localparam int          RF_GP_IDX  = 28;
  localparam int          RF_SP_IDX  = 29;
  localparam logic [31:0] RF_GP_INIT = 32'h0000_1800;
  localparam logic [31:0] RF_SP_INIT = 32'h0000_2ffe;

  typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboarded_if.sv
// Register-file request/response bundle: read ports, write port, reserve port, busy summary.
interface rf_scoreboarded_if
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
);

  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          re1;
  logic          re2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          rd1_busy;
  logic          rd2_busy;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          any_busy;

  modport master (
    output ra1, ra2, re1, re2, we, wa, wd, rsv_en, rsv_addr,
    input  rd1, rd2, rd1_busy, rd2_busy, any_busy
  );

  modport slave (
    input  ra1, ra2, re1, re2, we, wa, wd, rsv_en, rsv_addr,
    output rd1, rd2, rd1_busy, rd2_busy, any_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: reserve sets, write clears, reserve wins on the same edge.
module rf_scoreboard #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2,
  output logic          any_busy
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy;

  // Set is applied after clear so a same-edge reserve overrides the write's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en && clr_addr != '0) busy[clr_addr] <= 1'b0;
      if (set_en && set_addr != '0) busy[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    busy1    = (ra1 == '0) ? 1'b0 : busy[ra1];
    busy2    = (ra2 == '0) ? 1'b0 : busy[ra2];
    any_busy = |busy;
  end

endmodule

// File: rtl/rf_scoreboarded.sv
// Two-read/one-write register file with zero register, $gp/$sp reset values and busy scoreboard.
// Optional write-first read bypass enabled by defining RF_BYPASS_EN.
module rf_scoreboarded
  import rf_pkg::*;
#(
  parameter int            DW      = RF_DW,
  parameter int            AW      = RF_AW,
  parameter int            GP_IDX  = RF_GP_IDX,
  parameter logic [DW-1:0] GP_INIT = DW'(RF_GP_INIT),
  parameter int            SP_IDX  = RF_SP_IDX,
  parameter logic [DW-1:0] SP_INIT = DW'(RF_SP_INIT)
) (
  input logic              clk,
  input logic              rst_n,
  rf_scoreboarded_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1_q, rd2_q, rd1_n, rd2_n;
  logic          rb1_q, rb2_q, rb1_n, rb2_n;
  logic          sb_busy1, sb_busy2, sb_any;

  rf_scoreboard #(
    .AW(AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.rsv_en),
    .set_addr (bus.rsv_addr),
    .clr_en   (bus.we),
    .clr_addr (bus.wa),
    .ra1      (bus.ra1),
    .ra2      (bus.ra2),
    .busy1    (sb_busy1),
    .busy2    (sb_busy2),
    .any_busy (sb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      if (GP_IDX != 0) mem[AW'(GP_IDX)] <= GP_INIT;
      if (SP_IDX != 0) mem[AW'(SP_IDX)] <= SP_INIT;
    end else if (bus.we && bus.wa != '0) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Zero-register override is applied last so it also masks any bypass hit.
  always_comb begin
    rd1_n = mem[bus.ra1];
    rb1_n = sb_busy1;
    rd2_n = mem[bus.ra2];
    rb2_n = sb_busy2;
`ifdef RF_BYPASS_EN
    if (bus.we && bus.wa == bus.ra1) begin
      rd1_n = bus.wd;
      rb1_n = bus.rsv_en && (bus.rsv_addr == bus.ra1);
    end
    if (bus.we && bus.wa == bus.ra2) begin
      rd2_n = bus.wd;
      rb2_n = bus.rsv_en && (bus.rsv_addr == bus.ra2);
    end
`else
`endif
    if (bus.ra1 == '0) begin
      rd1_n = '0;
      rb1_n = 1'b0;
    end
    if (bus.ra2 == '0) begin
      rd2_n = '0;
      rb2_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rb1_q <= 1'b0;
      rd2_q <= '0;
      rb2_q <= 1'b0;
    end else begin
      if (bus.re1) begin
        rd1_q <= rd1_n;
        rb1_q <= rb1_n;
      end
      if (bus.re2) begin
        rd2_q <= rd2_n;
        rb2_q <= rb2_n;
      end
    end
  end

  assign bus.rd1      = rd1_q;
  assign bus.rd1_busy = rb1_q;
  assign bus.rd2      = rd2_q;
  assign bus.rd2_busy = rb2_q;
  assign bus.any_busy = sb_any;

endmodule

// File: tb/tb_rf_scoreboarded.sv
// Directed vector bench for rf_scoreboarded; expectations cover both bypass builds.
module tb_rf_scoreboarded;
  import rf_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    rf_addr_t    wa;
    logic [31:0] wd;
    logic        rsv;
    rf_addr_t    rsva;
    logic        re1;
    rf_addr_t    ra1;
    logic        re2;
    rf_addr_t    ra2;
    logic [31:0] rd1, rd1p;
    logic        b1, b1p;
    logic [31:0] rd2, rd2p;
    logic        b2, b2p;
    logic        any;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t v [22];

  rf_scoreboarded_if #(.DW(32), .AW(5)) bus ();

  rf_scoreboarded #(
    .DW(32), .AW(5), .GP_IDX(28), .GP_INIT(32'h0000_1800), .SP_IDX(29), .SP_INIT(32'h0000_2ffe)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] we, wa, wd, rsv, rsva, re1, ra1, re2, ra2,
                              rd1, b1, rd1p, b1p, rd2, b2, rd2p, b2p, any);
    vec_t r;
    r.we = we[0];   r.wa = wa[4:0];     r.wd = wd;
    r.rsv = rsv[0]; r.rsva = rsva[4:0];
    r.re1 = re1[0]; r.ra1 = ra1[4:0];   r.re2 = re2[0]; r.ra2 = ra2[4:0];
    r.rd1 = rd1;    r.b1 = b1[0];       r.rd1p = rd1p;  r.b1p = b1p[0];
    r.rd2 = rd2;    r.b2 = b2[0];       r.rd2p = rd2p;  r.b2p = b2p[0];
    r.any = any[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we = 1'b0;  bus.wa = '0;  bus.wd = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.re1 = 1'b0; bus.ra1 = '0; bus.re2 = 1'b0; bus.ra2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we wa wd            rsv ra re1 ra1 re2 ra2 | rd1 b1 rd1p b1p | rd2 b2 rd2p b2p | any
    v[0]  = mk(0, 0, 0,            0, 0, 1, 28, 1, 5,  32'h1800, 0, 32'h1800, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(0, 0, 0,            0, 0, 1, 29, 1, 7,  32'h2ffe, 0, 32'h2ffe, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0, 0,  32'h2ffe, 0, 32'h2ffe, 0, 0, 0, 0, 0, 0);
    v[3]  = mk(0, 0, 0,            0, 0, 1, 5,  0, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    v[4]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[5]  = mk(0, 0, 0,            0, 0, 1, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[6]  = mk(1, 7, 32'h11,       0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(1, 7, 32'h22,       0, 0, 1, 7,  0, 0,  32'h11, 0, 32'h22, 0, 0, 0, 0, 0, 0);
    v[8]  = mk(0, 0, 0,            0, 0, 1, 7,  0, 0,  32'h22, 0, 32'h22, 0, 0, 0, 0, 0, 0);
    v[9]  = mk(0, 0, 0,            1, 9, 0, 0,  0, 0,  32'h22, 0, 32'h22, 0, 0, 0, 0, 0, 1);
    v[10] = mk(0, 0, 0,            0, 0, 1, 9,  1, 9,  0, 1, 0, 1, 0, 1, 0, 1, 1);
    v[11] = mk(1, 9, 32'h99,       0, 0, 0, 0,  0, 0,  0, 1, 0, 1, 0, 1, 0, 1, 0);
    v[12] = mk(0, 0, 0,            0, 0, 1, 9,  0, 0,  32'h99, 0, 32'h99, 0, 0, 1, 0, 1, 0);
    v[13] = mk(1, 9, 32'h98,       1, 9, 0, 0,  0, 0,  32'h99, 0, 32'h99, 0, 0, 1, 0, 1, 1);
    v[14] = mk(0, 0, 0,            0, 0, 0, 0,  1, 9,  32'h99, 0, 32'h99, 0, 32'h98, 1, 32'h98, 1, 1);
    v[15] = mk(1, 9, 32'h97,       0, 0, 1, 9,  0, 0,  32'h98, 1, 32'h97, 0, 32'h98, 1, 32'h98, 1, 0);
    v[16] = mk(1, 9, 32'h96,       1, 9, 1, 9,  0, 0,  32'h97, 0, 32'h96, 1, 32'h98, 1, 32'h98, 1, 1);
    v[17] = mk(0, 0, 0,            1, 3, 0, 3,  0, 0,  32'h97, 0, 32'h96, 1, 32'h98, 1, 32'h98, 1, 1);
    v[18] = mk(1, 3, 32'h33,       0, 0, 0, 29, 1, 3,  32'h97, 0, 32'h96, 1, 0, 1, 32'h33, 0, 1);
    v[19] = mk(0, 0, 0,            0, 0, 0, 0,  1, 3,  32'h97, 0, 32'h96, 1, 32'h33, 0, 32'h33, 0, 1);
    v[20] = mk(1, 9, 0,            0, 0, 1, 9,  0, 0,  32'h96, 1, 0, 0, 32'h33, 0, 32'h33, 0, 0);
    v[21] = mk(0, 0, 0,            0, 0, 1, 28, 1, 28, 32'h1800, 0, 32'h1800, 0, 32'h1800, 0, 32'h1800, 0, 0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk ("por_rd1", bus.rd1, 32'h0);
    chk ("por_rd2", bus.rd2, 32'h0);
    chk1("por_any", bus.any_busy, 1'b0);
    rst_n = 1'b1;

    // Populate state so the later mid-cycle reset has something to clear.
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h55;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd6;
    bus.re1 = 1'b1; bus.ra1 = 5'd28; bus.re2 = 1'b1; bus.ra2 = 5'd29;
    tick();
    chk ("init_gp", bus.rd1, 32'h0000_1800);
    chk ("init_sp", bus.rd2, 32'h0000_2ffe);
    chk1("init_any", bus.any_busy, 1'b1);
    idle();
    bus.re1 = 1'b1; bus.ra1 = 5'd5;
    tick();
    chk ("pre_rst_r5", bus.rd1, 32'h55);
    chk1("pre_rst_b5", bus.rd1_busy, 1'b0);

    #3;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hAAAA;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    rst_n = 1'b0;
    #1;
    chk ("mid_rst_rd1", bus.rd1, 32'h0);
    chk ("mid_rst_rd2", bus.rd2, 32'h0);
    chk1("mid_rst_b1", bus.rd1_busy, 1'b0);
    chk1("mid_rst_any", bus.any_busy, 1'b0);
    tick();
    chk1("in_rst_any", bus.any_busy, 1'b0);
    chk ("in_rst_rd1", bus.rd1, 32'h0);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 22; i++) begin
      bus.we = v[i].we;   bus.wa = v[i].wa;   bus.wd = v[i].wd;
      bus.rsv_en = v[i].rsv; bus.rsv_addr = v[i].rsva;
      bus.re1 = v[i].re1; bus.ra1 = v[i].ra1;
      bus.re2 = v[i].re2; bus.ra2 = v[i].ra2;
      tick();
      chk ($sformatf("v%0d_rd1", i), bus.rd1, BYP ? v[i].rd1p : v[i].rd1);
      chk1($sformatf("v%0d_b1", i), bus.rd1_busy, BYP ? v[i].b1p : v[i].b1);
      chk ($sformatf("v%0d_rd2", i), bus.rd2, BYP ? v[i].rd2p : v[i].rd2);
      chk1($sformatf("v%0d_b2", i), bus.rd2_busy, BYP ? v[i].b2p : v[i].b2);
      chk1($sformatf("v%0d_any", i), bus.any_busy, v[i].any);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
